// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: widths, ALU control codes, requester IDs.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_BR = 1'b1;

    // Round-robin pointer names the requester that wins a tie.
    typedef enum logic {
        PTR_EX = 1'b0,
        PTR_BR = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/unsigned SLT/NOR; unknown codes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    // Operation select
    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered tie-break pointer.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    // Grant selection and pointer advance to the loser of this grant
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (ptr_q == PTR_EX) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end else begin
            gnt_o = 2'b00;
        end
        if (gnt_o[0]) begin
            ptr_d = PTR_BR;
        end else if (gnt_o[1]) begin
            ptr_d = PTR_EX;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_EX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a single tagged response slot.
// Optional statistics counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
   ,output logic [CNT_W-1:0]  stat_grant0,
    output logic [CNT_W-1:0]  stat_grant1,
    output logic [CNT_W-1:0]  stat_conflict
`endif
);

    logic              slot_free_s;
    logic              arb_en_s;
    logic [1:0]        gnt_s;
    logic [DATA_W-1:0] alu_a_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [CTRL_W-1:0] alu_ctrl_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_zero_s;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    // Readys must stay low while reset is held, even though the slot looks free.
    assign slot_free_s = !rsp_valid_q || rsp_ready;
    assign arb_en_s    = slot_free_s && rst_n;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (arb_en_s),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];

    // Route the granted requester's operands to the ALU
    always_comb begin
        alu_a_s    = req0_a;
        alu_b_s    = req0_b;
        alu_ctrl_s = req0_ctrl;
        if (gnt_s[1]) begin
            alu_a_s    = req1_a;
            alu_b_s    = req1_b;
            alu_ctrl_s = req1_ctrl;
        end else begin
            alu_a_s    = req0_a;
            alu_b_s    = req0_b;
            alu_ctrl_s = req0_ctrl;
        end
    end

    alu #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_alu (
        .a_i      (alu_a_s),
        .b_i      (alu_b_s),
        .ctrl_i   (alu_ctrl_s),
        .result_o (alu_result_s),
        .zero_o   (alu_zero_s)
    );

    // Response slot next state: load on accept, clear on drain, else hold
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (gnt_s != 2'b00) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_s[1] ? REQ_BR : REQ_EX;
            rsp_result_d = alu_result_s;
            rsp_zero_d   = alu_zero_s;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end else begin
            rsp_valid_d  = rsp_valid_q;
        end
    end

    // Response slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant0_q, grant1_q, conflict_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (gnt_s[0]) begin
                grant0_q <= sat_inc(grant0_q);
            end
            if (gnt_s[1]) begin
                grant1_q <= sat_inc(grant1_q);
            end
            if (req0_valid && req1_valid && slot_free_s) begin
                conflict_q <= sat_inc(conflict_q);
            end
        end
    end

    assign stat_grant0   = grant0_q;
    assign stat_grant1   = grant1_q;
    assign stat_conflict = conflict_q;
`else
    logic [CNT_W-1:0] stats_unused_s;
    assign stats_unused_s = '0;
`endif

endmodule
